// File: rtl/fpu_f32_mul_arbiter.sv
// Round-robin sharing of one F32 multiplier among NUM_REQ requesters, LATENCY-deep stallable pipe.
// Define FPU_MUL_ARB_COUNTER_EN to build the BUSY_COUNT issue counter; otherwise it reads 0.

module fpu_f32_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  // Round-to-nearest-even; subnormal inputs/results flush to zero, NaN results are canonical.
  logic              sign;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       mprod;
  logic [22:0]       frac;
  logic              guard, sticky, rnd;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_s;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    mprod  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp_s  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (mprod[47]) begin
      frac   = mprod[46:24];
      guard  = mprod[23];
      sticky = |mprod[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      frac   = mprod[45:23];
      guard  = mprod[22];
      sticky = |mprod[21:0];
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, rnd};
    if (frac_r[23]) exp_s = exp_s + 10'sd1;
    p = {sign, exp_s[7:0], frac_r[22:0]};
    if (exp_s >= 10'sd255) p = {sign, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0) p = {sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) p = 32'h7FC0_0000;
    else if (a_inf || b_inf) p = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero) p = {sign, 31'd0};
  end
endmodule

module fpu_f32_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [NUM_REQ*32-1:0] REQ_A,
  input  logic [NUM_REQ*32-1:0] REQ_B,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [ID_W-1:0]       RSP_ID,
  output logic [31:0]           RSP_O,
  output logic [31:0]           BUSY_COUNT
);
  logic            adv, gnt_any, issue;
  logic [ID_W-1:0] gnt_id, ptr;
  logic [ID_W:0]   idx;
  logic [LATENCY:1] vld;
  logic [ID_W-1:0] id_q [1:LATENCY];
  logic [31:0]     a_q, b_q, mul_p;

  assign RSP_VALID = vld[LATENCY];
  assign RSP_ID    = id_q[LATENCY];
  assign adv       = !RSP_VALID || RSP_READY;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && REQ_VALID[idx[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  // Ready is gated by reset so nothing appears granted while the pipe is held clear.
  assign issue     = adv && gnt_any && !RST;
  assign REQ_READY = issue ? ((NUM_REQ)'(1) << gnt_id) : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
      vld <= '0;
      a_q <= '0;
      b_q <= '0;
      for (int k = 1; k <= LATENCY; k++) id_q[k] <= '0;
    end else begin
      if (issue) ptr <= (gnt_id == (ID_W)'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      if (adv) begin
        vld[1] <= issue;
        if (issue) begin
          a_q     <= REQ_A[32*gnt_id +: 32];
          b_q     <= REQ_B[32*gnt_id +: 32];
          id_q[1] <= gnt_id;
        end
        for (int k = 2; k <= LATENCY; k++) begin
          vld[k]  <= vld[k-1];
          id_q[k] <= id_q[k-1];
        end
      end
    end
  end

  fpu_f32_mul u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  generate
    if (LATENCY == 1) begin : g_lat1
      assign RSP_O = mul_p;
    end else begin : g_latn
      logic [31:0] prod_q [2:LATENCY];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int k = 2; k <= LATENCY; k++) prod_q[k] <= '0;
        end else if (adv) begin
          prod_q[2] <= mul_p;
          for (int k = 3; k <= LATENCY; k++) prod_q[k] <= prod_q[k-1];
        end
      end
      assign RSP_O = prod_q[LATENCY];
    end
  endgenerate

`ifdef FPU_MUL_ARB_COUNTER_EN
  logic [31:0] busy_cnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        busy_cnt <= '0;
    else if (issue) busy_cnt <= busy_cnt + 32'd1;
  end
  assign BUSY_COUNT = busy_cnt;
`else
  assign BUSY_COUNT = '0;
`endif
endmodule
